nibble_packer: RTL and testbench



---
 rtl/nibble_packer.sv | 123 ++++++++++++
 tb/tb_nibble_packer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_packer.sv
// nibble_packer: drains a first-word-fall-through nibble FIFO and packs
// NIBBLES consecutive nibbles into one word on a valid/ready output port.
// A flush request emits a partially filled word so stream tails are not stranded.
module nibble_packer #(
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned NIBBLES = 4,
  parameter int unsigned CNT_W   = 4
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [DATA_W-1:0]           rdata,
  input  logic                        empty,
  output logic                        ren,
  input  logic                        flush,
  output logic [DATA_W*NIBBLES-1:0]   out_data,
  output logic [CNT_W-1:0]            out_count,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int unsigned WORD_W = DATA_W * NIBBLES;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t              r_state;
  logic [WORD_W-1:0]   r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic [WORD_W-1:0]   r_out_data;
  logic [CNT_W-1:0]    r_out_count;
  logic                r_out_valid;

  state_t              w_state_nxt;
  logic [WORD_W-1:0]   w_acc_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [WORD_W-1:0]   w_out_data_nxt;
  logic [CNT_W-1:0]    w_out_count_nxt;
  logic                w_out_valid_nxt;

  logic                w_ren;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic [CNT_W-1:0]    w_fill_n;
  logic                w_word_full;
  logic                w_flush_go;

  // Read strobe: only while filling, only when the FIFO has data, never in reset.
  assign w_ren = (r_state == FILL) & ~empty & ~RESET;

  // Nibble count after this cycle, and the two reasons to close the word.
  assign w_cnt_inc   = r_cnt + CNT_W'(1);
  assign w_fill_n    = r_cnt + CNT_W'(w_ren);
  assign w_word_full = w_ren & (w_cnt_inc == CNT_W'(NIBBLES));
  assign w_flush_go  = flush & (w_fill_n != CNT_W'(0));

  // Next-state and next-register values for the FILL/HOLD machine.
  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_cnt_nxt       = r_cnt;
    w_out_data_nxt  = r_out_data;
    w_out_count_nxt = r_out_count;
    w_out_valid_nxt = r_out_valid;

    unique case (r_state)
      FILL: begin
        if (w_ren) begin
          for (int i = 0; i < int'(NIBBLES); i++) begin
            if (r_cnt == CNT_W'(i)) begin
              w_acc_nxt[i*DATA_W +: DATA_W] = rdata;
            end
          end
          w_cnt_nxt = w_cnt_inc;
        end
        // Close the word when full or when a flush finds at least one nibble.
        if (w_word_full || w_flush_go) begin
          w_state_nxt     = HOLD;
          w_out_data_nxt  = w_acc_nxt;
          w_out_count_nxt = w_fill_n;
          w_out_valid_nxt = 1'b1;
        end
      end
      HOLD: begin
        // Word stays put until accepted; then the accumulator restarts empty.
        if (out_ready) begin
          w_state_nxt     = FILL;
          w_out_valid_nxt = 1'b0;
          w_cnt_nxt       = '0;
          w_acc_nxt       = '0;
        end
      end
      default: begin
        w_state_nxt = FILL;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= FILL;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_count <= w_out_count_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  assign ren       = w_ren;
  assign out_data  = r_out_data;
  assign out_count = r_out_count;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_nibble_packer.sv
// Self-checking bench for nibble_packer: directed vector table, a back-to-back
// stream, and randomized traffic compared against a queue-based word model.
module tb_nibble_packer;

  localparam int unsigned DATA_W  = 4;
  localparam int unsigned NIBBLES = 4;
  localparam int unsigned CNT_W   = 4;

  logic                       CLK;
  logic                       RESET;
  logic [DATA_W-1:0]          rdata;
  logic                       empty;
  logic                       ren;
  logic                       flush;
  logic [DATA_W*NIBBLES-1:0]  out_data;
  logic [CNT_W-1:0]           out_count;
  logic                       out_valid;
  logic                       out_ready;

  nibble_packer #(
    .DATA_W (DATA_W),
    .NIBBLES(NIBBLES),
    .CNT_W  (CNT_W)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .rdata    (rdata),
    .empty    (empty),
    .ren      (ren),
    .flush    (flush),
    .out_data (out_data),
    .out_count(out_count),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          rst;
    bit          emp;
    logic [3:0]  rd;
    bit          fl;
    bit          rdy;
    bit          e_ren;
    bit          e_valid;
    logic [15:0] e_data;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, bit emp, logic [3:0] rd, bit fl, bit rdy,
                              bit e_ren, bit e_valid, logic [15:0] e_data, logic [3:0] e_cnt);
    vec_t v;
    v.rst = rst; v.emp = emp; v.rd = rd; v.fl = fl; v.rdy = rdy;
    v.e_ren = e_ren; v.e_valid = e_valid; v.e_data = e_data; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Apply one directed vector: inputs at negedge, ren checked before the edge,
  // registered outputs checked shortly after it.
  task automatic apply_vec(input vec_t v, input int idx);
    @(negedge CLK);
    RESET = v.rst; empty = v.emp; rdata = v.rd; flush = v.fl; out_ready = v.rdy;
    #1;
    chk($sformatf("vec%0d_ren", idx), 32'(ren), 32'(v.e_ren));
    @(posedge CLK);
    #1;
    chk($sformatf("vec%0d_valid", idx), 32'(out_valid), 32'(v.e_valid));
    if (v.e_valid || v.rst) begin
      chk($sformatf("vec%0d_data", idx), 32'(out_data), 32'(v.e_data));
      chk($sformatf("vec%0d_count", idx), 32'(out_count), 32'(v.e_cnt));
    end
  endtask

  // Word-level reference model: a queue of collected nibbles and a held word.
  logic [3:0]  fifo_q[$];
  logic [3:0]  m_buf[$];
  bit          m_hold;
  bit          m_valid;
  logic [31:0] m_word;
  int          m_count;

  task automatic model_cycle(input bit rst, input bit fl, input bit rdy, input string tag);
    bit         exp_ren;
    logic [3:0] nib;
    nib = '0;
    @(negedge CLK);
    RESET = rst;
    empty = (fifo_q.size() == 0);
    rdata = empty ? 4'h0 : fifo_q[0];
    flush = fl;
    out_ready = rdy;
    #1;
    exp_ren = !m_hold && !empty && !rst;
    chk({tag, "_ren"}, 32'(ren), 32'(exp_ren));
    @(posedge CLK);
    if (exp_ren) nib = fifo_q.pop_front();
    if (rst) begin
      m_buf.delete();
      m_hold = 0; m_valid = 0; m_word = 0; m_count = 0;
    end else if (!m_hold) begin
      if (exp_ren) m_buf.push_back(nib);
      if (m_buf.size() == int'(NIBBLES) || (fl && m_buf.size() > 0)) begin
        m_word = 0;
        foreach (m_buf[i]) m_word = m_word | (32'(m_buf[i]) << (4 * i));
        m_count = m_buf.size();
        m_hold  = 1;
        m_valid = 1;
        m_buf.delete();
      end
    end else if (rdy) begin
      m_hold  = 0;
      m_valid = 0;
    end
    #1;
    chk({tag, "_valid"}, 32'(out_valid), 32'(m_valid));
    if (m_valid || rst) begin
      chk({tag, "_data"}, 32'(out_data), m_word);
      chk({tag, "_count"}, 32'(out_count), 32'(m_count));
    end
  endtask

  initial begin
    logic [15:0] got[$];
    bit          prev_valid;

    RESET = 1'b1; empty = 1'b1; rdata = '0; flush = 1'b0; out_ready = 1'b0;
    m_hold = 0; m_valid = 0; m_word = 0; m_count = 0;

    // Reset, then 1,2,3,4 with out_ready=1; word held exactly one cycle.
    vecs.push_back(mk(1,1,4'h0,0,1, 0,0,16'h0000,4'd0));
    vecs.push_back(mk(1,0,4'h9,0,1, 0,0,16'h0000,4'd0));
    vecs.push_back(mk(0,0,4'h1,0,1, 1,0,16'h0000,4'd0));
    vecs.push_back(mk(0,0,4'h2,0,1, 1,0,16'h0000,4'd0));
    vecs.push_back(mk(0,0,4'h3,0,1, 1,0,16'h0000,4'd0));
    vecs.push_back(mk(0,0,4'h4,0,1, 1,1,16'h4321,4'd4));
    vecs.push_back(mk(0,0,4'h5,0,1, 0,0,16'h0000,4'd0));
    // Refill right after handoff, then stall 5 cycles with data pending (flush ignored).
    vecs.push_back(mk(0,0,4'h5,0,1, 1,0,16'h0000,4'd0));
    vecs.push_back(mk(0,0,4'h6,0,1, 1,0,16'h0000,4'd0));
    vecs.push_back(mk(0,0,4'h7,0,1, 1,0,16'h0000,4'd0));
    vecs.push_back(mk(0,0,4'h8,0,1, 1,1,16'h8765,4'd4));
    vecs.push_back(mk(0,0,4'h9,0,0, 0,1,16'h8765,4'd4));
    vecs.push_back(mk(0,0,4'h9,0,0, 0,1,16'h8765,4'd4));
    vecs.push_back(mk(0,0,4'h9,1,0, 0,1,16'h8765,4'd4));
    vecs.push_back(mk(0,0,4'h9,0,0, 0,1,16'h8765,4'd4));
    vecs.push_back(mk(0,0,4'h9,0,0, 0,1,16'h8765,4'd4));
    vecs.push_back(mk(0,0,4'h9,0,1, 0,0,16'h0000,4'd0));
    vecs.push_back(mk(0,1,4'h0,0,1, 0,0,16'h0000,4'd0));
    // A,B then FIFO empty 3 cycles then flush; next word restarts at bit 0.
    vecs.push_back(mk(0,0,4'hA,0,1, 1,0,16'h0000,4'd0));
    vecs.push_back(mk(0,0,4'hB,0,1, 1,0,16'h0000,4'd0));
    vecs.push_back(mk(0,1,4'h0,0,1, 0,0,16'h0000,4'd0));
    vecs.push_back(mk(0,1,4'h0,0,1, 0,0,16'h0000,4'd0));
    vecs.push_back(mk(0,1,4'h0,0,1, 0,0,16'h0000,4'd0));
    vecs.push_back(mk(0,1,4'h0,1,1, 0,1,16'h00BA,4'd2));
    vecs.push_back(mk(0,0,4'hC,0,1, 0,0,16'h0000,4'd0));
    vecs.push_back(mk(0,0,4'hC,0,1, 1,0,16'h0000,4'd0));
    vecs.push_back(mk(0,0,4'hD,0,1, 1,0,16'h0000,4'd0));
    vecs.push_back(mk(0,0,4'hE,0,1, 1,0,16'h0000,4'd0));
    vecs.push_back(mk(0,0,4'hF,0,1, 1,1,16'hFEDC,4'd4));
    vecs.push_back(mk(0,1,4'h0,0,1, 0,0,16'h0000,4'd0));
    // Flush coincident with the 3rd read; then flush with nothing collected.
    vecs.push_back(mk(0,0,4'h5,0,1, 1,0,16'h0000,4'd0));
    vecs.push_back(mk(0,0,4'h6,0,1, 1,0,16'h0000,4'd0));
    vecs.push_back(mk(0,0,4'h7,1,1, 1,1,16'h0765,4'd3));
    vecs.push_back(mk(0,1,4'h0,0,1, 0,0,16'h0000,4'd0));
    vecs.push_back(mk(0,1,4'h0,1,1, 0,0,16'h0000,4'd0));
    vecs.push_back(mk(0,1,4'h0,0,1, 0,0,16'h0000,4'd0));
    // Reset with three nibbles collected, then a clean 4-nibble word.
    vecs.push_back(mk(0,0,4'h1,0,1, 1,0,16'h0000,4'd0));
    vecs.push_back(mk(0,0,4'h2,0,1, 1,0,16'h0000,4'd0));
    vecs.push_back(mk(0,0,4'h3,0,1, 1,0,16'h0000,4'd0));
    vecs.push_back(mk(1,0,4'h4,0,1, 0,0,16'h0000,4'd0));
    vecs.push_back(mk(0,0,4'h1,0,1, 1,0,16'h0000,4'd0));
    vecs.push_back(mk(0,0,4'h2,0,1, 1,0,16'h0000,4'd0));
    vecs.push_back(mk(0,0,4'h3,0,1, 1,0,16'h0000,4'd0));
    vecs.push_back(mk(0,0,4'h4,0,1, 1,1,16'h4321,4'd4));
    // Reset while holding an un-accepted word.
    vecs.push_back(mk(0,0,4'h5,0,0, 0,1,16'h4321,4'd4));
    vecs.push_back(mk(1,0,4'h5,0,0, 0,0,16'h0000,4'd0));
    vecs.push_back(mk(0,0,4'hA,0,0, 1,0,16'h0000,4'd0));
    vecs.push_back(mk(0,0,4'hB,0,0, 1,0,16'h0000,4'd0));
    vecs.push_back(mk(0,0,4'hC,0,0, 1,0,16'h0000,4'd0));
    vecs.push_back(mk(0,0,4'hD,0,0, 1,1,16'hDCBA,4'd4));
    vecs.push_back(mk(0,1,4'h0,0,1, 0,0,16'h0000,4'd0));

    foreach (vecs[i]) apply_vec(vecs[i], i);

    // Back-to-back: 0..7 preloaded, FIFO never empty while filling.
    model_cycle(1, 0, 1, "b2b_rst");
    for (int n = 0; n < 8; n++) fifo_q.push_back(4'(n));
    prev_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      model_cycle(0, 0, 1, "b2b");
      if (out_valid && !prev_valid) got.push_back(out_data);
      prev_valid = out_valid;
    end
    chk("b2b_words", 32'(got.size()), 32'd2);
    if (got.size() >= 2) begin
      chk("b2b_word0", 32'(got[0]), 32'h3210);
      chk("b2b_word1", 32'(got[1]), 32'h7654);
    end

    // Randomized traffic against the model.
    fifo_q.delete();
    model_cycle(1, 0, 1, "rnd_rst");
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(99) < 55 && fifo_q.size() < 16) fifo_q.push_back(4'($urandom_range(15)));
      model_cycle($urandom_range(99) < 2, $urandom_range(99) < 10,
                  $urandom_range(99) < 50, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
